// File: rtl/am2940_word_ctrl.sv
// rtl/am2940_word_ctrl.sv - Am2940 control register, word count and instruction decode
// Optional feature: AM2940_ADDR_CARRY_MODE_EN enables mode 10 termination on addr_carry.
module am2940_word_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic [2:0]       instr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cnten,
  input  logic             addr_carry,
  output logic             addr_load,
  output logic             addr_enable,
  output logic             addr_up,
  output logic [WIDTH-1:0] data_out,
  output logic             data_oe,
  output logic             done,
  output logic [2:0]       cr
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef AM2940_ADDR_CARRY_MODE_EN
  localparam logic CARRY_MODE_EN = 1'b1;
`else
  localparam logic CARRY_MODE_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [2:0]       cr_nxt;
  logic [WIDTH-1:0] wcr, wcr_nxt;
  logic [WIDTH-1:0] wc, wc_nxt;
  logic [WIDTH-1:0] wc_inc;
  logic             terminal;

  assign wc_inc  = wc + WIDTH'(1);
  assign addr_up = ~cr[2];
  assign done    = (state == DONE);

  // With the carry feature off, mode 10 never terminates and so counts like free-run.
  always_comb begin
    terminal = 1'b0;
    case (cr[1:0])
      2'b00:   terminal = (wc == WIDTH'(1));
      2'b01:   terminal = (wc_inc == wcr);
      2'b10:   terminal = CARRY_MODE_EN & addr_carry;
      default: terminal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    cr_nxt      = cr;
    wcr_nxt     = wcr;
    wc_nxt      = wc;
    addr_load   = 1'b0;
    addr_enable = 1'b0;
    data_out    = '0;
    data_oe     = 1'b0;
    case (instr)
      3'd0: begin
        cr_nxt    = data_in[2:0];
        state_nxt = IDLE;
      end
      3'd1: begin
        data_out = {{(WIDTH-3){1'b0}}, cr};
        data_oe  = 1'b1;
      end
      3'd2: begin
        data_out = wc;
        data_oe  = 1'b1;
      end
      3'd3: begin
        data_out = wcr;
        data_oe  = 1'b1;
      end
      3'd4: begin
        wc_nxt    = (cr[1:0] == 2'b00) ? wcr : '0;
        state_nxt = RUN;
      end
      3'd5: addr_load = 1'b1;
      3'd6: begin
        wcr_nxt   = data_in;
        wc_nxt    = (cr[1:0] == 2'b00) ? data_in : '0;
        state_nxt = RUN;
      end
      default: begin
        if (cnten && state == RUN) begin
          addr_enable = 1'b1;
          wc_nxt      = (cr[1:0] == 2'b00) ? wc - WIDTH'(1) : wc_inc;
          if (terminal) state_nxt = DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      cr    <= 3'b000;
      wcr   <= '0;
      wc    <= '0;
    end else begin
      state <= state_nxt;
      cr    <= cr_nxt;
      wcr   <= wcr_nxt;
      wc    <= wc_nxt;
    end
  end

endmodule

// File: doc/am2940_word_ctrl.md
# am2940_word_ctrl

Control and word-count stage of the Am2940-style DMA address generator. It sits directly upstream of the 4-bit address `counter` slices and drives their `load`, `enable` and `up` inputs. It holds the 3-bit control register, the word-count register and the word counter, and decodes the 3-bit instruction bus. It raises `done` when the programmed transfer count or termination condition is reached, and then freezes the address counter.

## Interface
Parameters:
- `WIDTH`, 8: width of the word-count register, the word counter and the data bus.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `res`  in  1  reset. Synchronous, active-high; has priority over every other input.
- `instr`  in  3  instruction code, decoded every cycle.
- `data_in`  in  WIDTH  shared data bus. Bits [3:0] are also wired to the counter's `data_in`.
- `cnten`  in  1  count enable; qualifies the ENCNT instruction.
- `addr_carry`  in  1  address counter `carry_out`.
- `addr_load`  out  1  to counter `load`; combinational.
- `addr_enable`  out  1  to counter `enable`; combinational.
- `addr_up`  out  1  to counter `up`; equals `~cr[2]`.
- `data_out`  out  WIDTH  read-back value; 0 when not reading.
- `data_oe`  out  1  high during read instructions.
- `done`  out  1  registered termination flag.
- `cr`  out  3  control register contents.

## Operation
Registers:
- `cr[1:0]` selects the mode.
- `cr[2]` selects address direction: 0 = up, 1 = down.
- `wcr` holds the programmed word count.
- `wc` is the running word counter.
- FSM states are IDLE, RUN and DONE.

Instructions:
- 0 WRCR: `cr <= data_in[2:0]`, `done <= 0`, FSM goes to IDLE.
- 1 RDCR: `data_out = {0, cr}`, `data_oe = 1`.
- 2 RDWC: `data_out = wc`, `data_oe = 1`.
- 3 RDWCR: `data_out = wcr`, `data_oe = 1`.
- 4 REINIT: `wc <= (mode==00) ? wcr : 0`, `done <= 0`, FSM goes to RUN.
- 5 LDADDR: `addr_load = 1`. No internal state change.
- 6 LDWC: `wcr <= data_in`, `wc <= (mode==00) ? data_in : 0`, `done <= 0`, FSM goes to RUN.
- 7 ENCNT: a transfer occurs iff `cnten && state==RUN`.
  - During a transfer, `addr_enable = 1` and `wc` updates.
  - In IDLE or DONE, ENCNT is a no-op and `addr_enable = 0`.

Modes, applied per transfer:
- 00 down-count: `wc <= wc-1`. Terminal transfer is when `wc==1`.
- 01 compare: `wc <= wc+1`. Terminal transfer is when `wc+1 == wcr` (mod 2^WIDTH).
- 10 address-carry: `wc <= wc+1`. Terminal transfer is when `addr_carry==1` in that cycle.
- 11 free-run: `wc <= wc+1` with wrap. There is never a terminal transfer.

A terminal transfer moves the FSM from RUN to DONE and sets `done <= 1`.

Boundary and arithmetic rules:
- All arithmetic is modulo 2^WIDTH.
- Mode 00 or 01 with `wcr==0` gives exactly 2^WIDTH transfers.
- A terminal transfer still asserts `addr_enable`, so the counter takes its final step.
- Changing mode via WRCR returns the FSM to IDLE. REINIT or LDWC is required to re-arm.

## Timing
- Reset (`res==1` at an edge): `cr=000`, `wcr=0`, `wc=0`, `done=0`, FSM in IDLE.
- Outputs after reset: `addr_up=1`, `addr_load=0`, `addr_enable=0`, `data_out=0`, `data_oe=0`.
- `res` mid-transfer aborts the transfer; reset values appear after that edge.
- `addr_load`, `addr_enable`, `addr_up`, `data_out` and `data_oe` are combinational from `instr`, `cnten`, state and registers, with zero latency. The counter samples them on the same edge that updates `wc`.
- `done` rises one edge after the terminal transfer edge. In that same cycle ENCNT no longer produces `addr_enable`.
- `done` falls on the edge that executes REINIT, LDWC or WRCR.

## Configuration
- `AM2940_ADDR_CARRY_MODE_EN` defined: mode 10 operates as specified above and `addr_carry` is used.
- `AM2940_ADDR_CARRY_MODE_EN` undefined:
  - mode 10 behaves exactly as mode 11 (free-run);
  - `addr_carry` is ignored;
  - `cr` still stores the written value 10.

## Test plan
- Reset check: hold `res=1` for 2 cycles with `instr=7` and `cnten=1`.
  - Expect `done=0`, `cr=000`, `wc=0` and `addr_enable=0` throughout.
- Mode 00 count of 3: WRCR 000, then LDWC 3, then ENCNT with `cnten=1` for 5 cycles.
  - Expect `addr_enable` high for exactly 3 cycles.
  - Expect `wc` to step 3→2→1→0.
  - Expect `done=1` from the 4th cycle and RDWC=0.
- Mode 01 with wraparound count: WRCR 001, then LDWC 0, then ENCNT for 256 cycles.
  - Expect `done` to rise after exactly 256 transfers, with RDWC=0.
- Direction and load: WRCR 100, then LDADDR with `data_in=0x0A`.
  - Expect `addr_load=1` and `addr_up=0` for one cycle.
  - Then ENCNT for 2 cycles in mode 00 with `wcr=5`: expect `addr_enable=1`, `wc=3`.
- Mode 10: WRCR 010, then REINIT, then ENCNT with `addr_carry` pulsed on the 4th transfer.
  - With `AM2940_ADDR_CARRY_MODE_EN`: expect `done=1` next cycle and `wc=4`.
  - Without the macro: expect `done=0` and counting to continue.
- Re-arm and reset mid-run:
  - From DONE, REINIT: expect `done=0` next cycle and counting resumes.
  - Assert `res` during RUN: expect all registers at reset values on the next edge.
